seq_mem_writer: RTL
===================

// Module: seq_mem_writer
// PURPOSE
//   Write side of the 16-entry sequential memory path. Accepts data words over a
//   valid/ready handshake and stores them at sequential addresses 0..DEPTH-1.
//   Provides a registered random-access read port driven by the address generator.
//   Asserts full once a complete frame has been loaded.
// PARAMETERS
//   DATA_W  8   width of each stored word
//   DEPTH   16  number of words (must equal 2**ADDR_W)
//   ADDR_W  4   address width for wr_addr and rd_addr
// PORTS
//   clk       in   1       single clock; all logic on posedge
//   reset     in   1       synchronous, active-low reset
//   start     in   1       one-cycle pulse: begin or restart a load at address 0
//   wr_valid  in   1       wr_data is valid this cycle
//   wr_data   in   DATA_W  word to store
//   wr_ready  out  1       block accepts a word this cycle
//   wr_addr   out  ADDR_W  address the next accepted word is written to
//   rd_addr   in   ADDR_W  read address (from the address generator)
//   rd_data   out  DATA_W  registered mem[rd_addr]
//   busy      out  1       state == LOAD
//   full      out  1       state == FULL
// BEHAVIOUR
//   - Reset (reset==0 at posedge clk): state=IDLE, wr_addr=0, rd_data=0, busy=0,
//     full=0. Memory contents are NOT cleared. Reset wins over every other input.
//   - FSM states: IDLE, LOAD, FULL.
//     IDLE: start -> LOAD with wr_addr=0. Writes are ignored.
//     LOAD: a transfer happens when wr_valid && wr_ready at posedge clk.
//       mem[wr_addr]<=wr_data and wr_addr<=wr_addr+1.
//       A transfer with wr_addr==DEPTH-1 -> FULL, and wr_addr wraps to 0.
//       start in LOAD: wr_addr<=0 and the state stays LOAD. No write occurs that cycle.
//     FULL: writes are ignored. start -> LOAD with wr_addr=0, overwriting the old frame.
//   - wr_ready = (state==LOAD) && !start. This is combinational from state and start.
//     A word presented with start is therefore never accepted.
//   - wr_valid without wr_ready is a no-op. wr_data is sampled only on a transfer.
//     The sender holds the word until a transfer occurs.
//   - Read port is active in every state, with 1-cycle latency:
//     rd_data <= mem[rd_addr] on each posedge.
//   - Read and write to the same address in the same cycle: rd_data returns the OLD
//     word. The new word is visible on the following read.
//   - wr_addr arithmetic is modulo DEPTH. No other counter exists.
//     A write at DEPTH-1 while in LOAD always ends the frame.
//   - Reset mid-load returns the block to IDLE immediately. Partially written words
//     stay in memory, and full stays 0.
// TESTING
//   1. Hold reset=0 for 2 clks -> wr_ready=0, busy=0, full=0, wr_addr=0, rd_data=0.
//   2. Pulse start, then 16 back-to-back writes of 8'h10+i.
//      -> wr_addr steps 0..15. After the 16th write: full=1, wr_ready=0, wr_addr=0.
//      -> Sweeping rd_addr 0..15 returns 8'h10+i one cycle later.
//   3. In LOAD, drive wr_valid on alternate cycles with data 8'hA0+i.
//      -> Only handshaked words are stored. wr_addr advances only on transfers.
//   4. In IDLE and in FULL, drive wr_valid=1 with 8'hFF for 5 clks.
//      -> wr_ready=0 and memory is unchanged (readback).
//   5. After 5 writes, assert start with wr_valid=1 and 8'h55.
//      -> wr_ready=0 that cycle and wr_addr=0. The next transfer (8'h66) lands at address 0.
//   6. Set rd_addr=3 and write 8'h77 to address 3 in the same cycle.
//      -> rd_data shows the old word first, then 8'h77 on the next cycle.
//   7. Drop reset after 7 writes -> IDLE, wr_addr=0, full=0. Addresses 0..6 retain their data.

Source files
------------

// File: rtl/seq_mem_writer_if.sv
// Write handshake, read port and status bundle for seq_mem_writer.
// master drives words and read addresses; slave is the memory writer.
interface seq_mem_writer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
);
  logic              start;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              full;

  modport master (
    output start, wr_valid, wr_data, rd_addr,
    input  wr_ready, wr_addr, rd_data, busy, full
  );

  modport slave (
    input  start, wr_valid, wr_data, rd_addr,
    output wr_ready, wr_addr, rd_data, busy, full
  );
endinterface

// File: rtl/seq_mem_writer.sv
// Loads a frame of DEPTH words at sequential addresses over valid/ready and
// exposes a registered random-access read port; full marks a completed frame.
module seq_mem_writer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input logic               clk,
  input logic               reset,
  seq_mem_writer_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              xfer;

  // start takes priority over a presented word, so it can never be accepted
  assign bus.wr_ready = (state_q == StLoad) && !bus.start;
  assign xfer         = bus.wr_ready && bus.wr_valid;

  assign bus.wr_addr = wr_addr_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = (state_q == StLoad);
  assign bus.full    = (state_q == StFull);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      wr_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      // Read-before-write: a same-address write is seen on the following read
      rd_data_q <= mem_q[bus.rd_addr];
      if (xfer) begin
        mem_q[wr_addr_q] <= bus.wr_data;
      end
      unique case (state_q)
        StIdle, StFull: begin
          if (bus.start) begin
            state_q   <= StLoad;
            wr_addr_q <= '0;
          end
        end
        StLoad: begin
          if (bus.start) begin
            wr_addr_q <= '0;
          end else if (bus.wr_valid) begin
            wr_addr_q <= wr_addr_q + ADDR_W'(1);
            if (wr_addr_q == LastAddr) begin
              state_q <= StFull;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
